// File: rtl/fifo_read_arbiter.sv
// fifo_read_arbiter: registered round-robin arbiter and one-word output buffer
// between N_SRC first-word-fall-through source FIFOs and a single sink.
// Optional build macro: FIFO_ARB_TLU_PRIO_EN gives source 0 (TLU) strict priority.
module fifo_read_arbiter #(
  parameter int unsigned N_SRC      = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic                          BUS_CLK,
  input  logic                          BUS_RST_N,
  input  logic [N_SRC-1:0]              SRC_EN,
  input  logic [N_SRC-1:0]              SRC_EMPTY,
  input  logic [N_SRC*DATA_WIDTH-1:0]   SRC_DATA,
  output logic [N_SRC-1:0]              SRC_READ,
  input  logic                          OUT_READ,
  output logic                          OUT_EMPTY,
  output logic [DATA_WIDTH-1:0]         OUT_DATA,
  output logic [N_SRC-1:0]              GRANT,
  output logic                          BUSY
);

  localparam int unsigned IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int unsigned CNT_W = 8;

  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(N_SRC - 1);
  localparam logic [N_SRC-1:0] GNT_ONE   = N_SRC'(1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [N_SRC-1:0]       grant_q, grant_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   valid_q, valid_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   busy_q, busy_d;

  logic [N_SRC-1:0]       req_c;
  logic                   load_ok_c;
  logic                   gnt_req_c;
  logic [DATA_WIDTH-1:0]  gnt_data_c;
  logic                   pop_c;
  logic                   preempt_c;
  logic [IDX_W-1:0]       pick_c;
  logic [CNT_W-1:0]       cnt_inc_c;

  // First requesting index scanning upward from last+1 with wrap-around.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_SRC-1:0] req,
                                               input logic [IDX_W-1:0] last);
    logic [IDX_W-1:0] pick;
    logic             found;
    int unsigned      cand;
    pick  = last;
    found = 1'b0;
    for (int unsigned k = 1; k <= N_SRC; k++) begin
      cand = (32'(last) + k) % N_SRC;
      if (!found && req[IDX_W'(cand)]) begin
        pick  = IDX_W'(cand);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign req_c     = SRC_EN & ~SRC_EMPTY;
  assign load_ok_c = ~valid_q | OUT_READ;
  assign cnt_inc_c = cnt_q + CNT_ONE;

  // Request flag and head word of the currently granted source.
  always_comb begin
    gnt_req_c  = 1'b0;
    gnt_data_c = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (last_q == IDX_W'(i)) begin
        gnt_req_c  = req_c[i];
        gnt_data_c = SRC_DATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Arbitration choice and TLU pre-emption of an FE burst.
`ifdef FIFO_ARB_TLU_PRIO_EN
  always_comb begin
    pick_c    = req_c[0] ? '0 : rr_pick(req_c, last_q);
    preempt_c = (last_q != '0) && req_c[0];
  end
`else
  always_comb begin
    pick_c    = rr_pick(req_c, last_q);
    preempt_c = 1'b0;
  end
`endif

  // Next-state, grant, burst count, output buffer and pop strobe.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    data_d   = data_q;
    busy_d   = (|req_c) | valid_q;
    pop_c    = 1'b0;
    SRC_READ = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (|req_c) begin
          grant_d = GNT_ONE << pick_c;
          last_d  = pick_c;
          cnt_d   = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // A stalled sink holds the grant without popping.
        if (load_ok_c) begin
          if (gnt_req_c) begin
            pop_c = 1'b1;
            cnt_d = cnt_inc_c;
            if ((cnt_inc_c == BURST_MAX) || preempt_c) begin
              grant_d = '0;
              state_d = ST_IDLE;
            end
          end else begin
            grant_d = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase

    // A pop overwrites the buffer even when the sink reads the same cycle.
    if (pop_c) begin
      data_d   = gnt_data_c;
      valid_d  = 1'b1;
      SRC_READ = grant_q;
    end else if (OUT_READ) begin
      valid_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
    end
  end

  assign OUT_EMPTY = ~valid_q;
  assign OUT_DATA  = data_q;
  assign GRANT     = grant_q;
  assign BUSY      = busy_q;

endmodule
